// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: constants, bus port macro and FSM encoding shared by the
// Wishbone RAM slave and the CPU that boots out of it.

`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

// Standard Wishbone slave port list, for blocks that want the plain bundle.
`ifndef WB_SLAVE_PORTS
`define WB_SLAVE_PORTS(DW) \
  input  logic [63:0]     wb_adr_i, \
  input  logic [DW-1:0]   wb_dat_i, \
  output logic [DW-1:0]   wb_dat_o, \
  input  logic            wb_we_i, \
  input  logic [DW/8-1:0] wb_sel_i, \
  input  logic            wb_stb_i, \
  input  logic            wb_cyc_i, \
  output logic            wb_ack_o, \
  output logic            wb_err_o
`endif

package wb_ram_pkg;

  // Bus data width used across the SoC.
  localparam int DAT_WIDTH_DEF = `DAT_WIDTH;

  // Byte address width of the Wishbone bus.
  localparam int ADR_WIDTH = 64;

  // The CPU fetches its first instruction from the bottom of this RAM, so the
  // PC reset value and the RAM base address are the same constant.
  localparam logic [ADR_WIDTH-1:0] PC_RESET_ADR = 64'h0000_8000_0000_0000;
  localparam logic [ADR_WIDTH-1:0] BASE_ADR_DEF = PC_RESET_ADR;

  // Slave FSM states, binary encoded in a single register.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } wb_state_e;

  // A request is refused when it is not word aligned or falls outside
  // the window [base, limit).
  function automatic logic isIllegalAdr(
    input logic [ADR_WIDTH-1:0] adr,
    input logic [ADR_WIDTH-1:0] base,
    input logic [ADR_WIDTH-1:0] limit
  );
    return (adr[2:0] != 3'b000) || (adr < base) || (adr >= limit);
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// wb_ram_array: DEPTH x DAT_WIDTH synchronous RAM with per-byte write
// enables and a registered read port that holds its value between reads.

module wb_ram_array #(
  parameter int DAT_WIDTH = 64,
  parameter int DEPTH     = 512
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DAT_WIDTH/8-1:0]       i_we,
  input  logic                         i_re,
  input  logic [$clog2(DEPTH)-1:0]     i_idx,
  input  logic [DAT_WIDTH-1:0]         i_wdat,
  output logic [DAT_WIDTH-1:0]         o_rdat
);

  localparam int SEL_W = DAT_WIDTH / 8;

  // Storage has no reset so it maps onto block RAM; contents are undefined
  // until written.
  logic [DAT_WIDTH-1:0] r_mem [DEPTH];
  logic [DAT_WIDTH-1:0] r_rdat;

  // Byte-lane write: only lanes with their enable set take the new data.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < SEL_W; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdat[8*b +: 8];
      end
    end
  end

  // Read register: loads only on a read, so the bus sees the last read word
  // until the next read; reset clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdat <= '0;
    end else if (i_re) begin
      r_rdat <= r_mem[i_idx];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/wb_ram.sv
// wb_ram: Wishbone classic slave in front of a byte-writable RAM. Every
// request goes IDLE -> ACCESS -> RESP (ack) or IDLE -> ERR (err), so a
// strobe held through the termination cycle is only re-sampled in IDLE.

`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module wb_ram
  import wb_ram_pkg::*;
#(
  parameter int                    DAT_WIDTH = DAT_WIDTH_DEF,
  parameter logic [ADR_WIDTH-1:0]  BASE_ADR  = BASE_ADR_DEF,
  parameter int                    DEPTH     = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADR_WIDTH-1:0]     wb_adr_i,
  input  logic [DAT_WIDTH-1:0]     wb_dat_i,
  output logic [DAT_WIDTH-1:0]     wb_dat_o,
  input  logic                     wb_we_i,
  input  logic [DAT_WIDTH/8-1:0]   wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o
);

  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);

  // First byte address past the end of the RAM window.
  localparam logic [ADR_WIDTH-1:0] LIMIT_ADR =
    BASE_ADR + (ADR_WIDTH'(DEPTH) * ADR_WIDTH'(8));

  wb_state_e              r_state;
  wb_state_e              w_nextState;

  logic [ADR_WIDTH-1:0]   r_adr;
  logic                   r_we;
  logic [SEL_W-1:0]       r_sel;
  logic [DAT_WIDTH-1:0]   r_dat;
  logic                   r_ack;
  logic                   r_err;

  logic                   w_req;
  logic                   w_illegal;
  logic [ADR_WIDTH-1:0]   w_offset;
  logic [AW-1:0]          w_idx;
  logic [SEL_W-1:0]       w_ramWe;
  logic                   w_ramRe;
  logic                   w_unused;

  assign w_req     = wb_stb_i & wb_cyc_i;
  assign w_illegal = isIllegalAdr(wb_adr_i, BASE_ADR, LIMIT_ADR);

  // Word index comes from the latched address; the alignment bits and the
  // bits above the RAM size are known to be zero for a legal request.
  assign w_offset = r_adr - BASE_ADR;
  assign w_idx    = w_offset[AW+2:3];
  assign w_unused = ^{w_offset[ADR_WIDTH-1:AW+3], w_offset[2:0]};

  // State register; reset drops any cycle in flight back to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: IDLE is the only state that looks at the strobe.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_nextState = w_illegal ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_nextState = wb_cyc_i ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      ST_ERR: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Capture the request in IDLE so the RAM access uses stable values even if
  // the master changes the bus afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_adr <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_dat <= '0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_adr <= wb_adr_i;
      r_we  <= wb_we_i;
      r_sel <= wb_sel_i;
      r_dat <= wb_dat_i;
    end
  end

  // Termination flags are registered copies of "entering RESP/ERR", so they
  // are high for exactly the one cycle spent in that state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= (w_nextState == ST_RESP);
      r_err <= (w_nextState == ST_ERR);
    end
  end

  // RAM strobes fire only in ACCESS while the master still holds the cycle;
  // reads ignore sel and always fetch the whole word.
  always_comb begin
    w_ramWe = '0;
    w_ramRe = 1'b0;
    if ((r_state == ST_ACCESS) && wb_cyc_i) begin
      if (r_we) begin
        w_ramWe = r_sel;
      end else begin
        w_ramRe = 1'b1;
      end
    end
  end

  wb_ram_array #(
    .DAT_WIDTH (DAT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_we   (w_ramWe),
    .i_re   (w_ramRe),
    .i_idx  (w_idx),
    .i_wdat (r_dat),
    .o_rdat (wb_dat_o)
  );

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule
